// File: rtl/wash_pkg.sv
// Shared types and constants for the washing-machine program sequencer.
package wash_pkg;

  // Top-level sequencer state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } top_state_e;

  // Phase within a stage.
  typedef enum logic [1:0] {
    PH_FILL    = 2'd0,
    PH_AGITATE = 2'd1,
    PH_DRAIN   = 2'd2,
    PH_SPIN    = 2'd3
  } phase_e;

  // Stage of the wash program.
  typedef enum logic [1:0] {
    STG_WASH  = 2'd0,
    STG_RINSE = 2'd1,
    STG_SPIN  = 2'd2
  } stage_e;

  // Program (mode) codes.
  localparam logic [1:0] MODE_STANDARD   = 2'd0;
  localparam logic [1:0] MODE_QUICK      = 2'd1;
  localparam logic [1:0] MODE_RINSE_SPIN = 2'd2;
  localparam logic [1:0] MODE_SPIN_ONLY  = 2'd3;

  // Bit positions inside the stage-enable mask {wash, rinse, spin}.
  localparam int EN_WASH  = 2;
  localparam int EN_RINSE = 1;
  localparam int EN_SPIN  = 0;

  // Default durations, in 1 Hz ticks.
  localparam int unsigned DEF_FILL_T  = 3;
  localparam int unsigned DEF_WASH_T  = 9;
  localparam int unsigned DEF_RINSE_T = 6;
  localparam int unsigned DEF_DRAIN_T = 3;
  localparam int unsigned DEF_SPIN_T  = 6;
  localparam int unsigned DEF_BUZZ_T  = 10;

  // Program select wraps 0->1->2->3->0.
  function automatic logic [1:0] next_mode(input logic [1:0] m);
    return m + 2'd1;
  endfunction

endpackage

// File: rtl/wash_plan.sv
// Combinational program table: mode -> enabled stages and total run time.
module wash_plan
  import wash_pkg::*;
#(
  parameter int unsigned FILL_T  = DEF_FILL_T,
  parameter int unsigned WASH_T  = DEF_WASH_T,
  parameter int unsigned RINSE_T = DEF_RINSE_T,
  parameter int unsigned DRAIN_T = DEF_DRAIN_T,
  parameter int unsigned SPIN_T  = DEF_SPIN_T
) (
  input  logic [1:0] mode,
  output logic [2:0] stage_en,
  output logic [6:0] total_time
);

  localparam logic [6:0] WASH_STAGE_T  = 7'(FILL_T + WASH_T + DRAIN_T);
  localparam logic [6:0] RINSE_STAGE_T = 7'(FILL_T + RINSE_T + DRAIN_T);
  localparam logic [6:0] SPIN_STAGE_T  = 7'(SPIN_T);

  // Look up the stage mask and the sum of the enabled stage durations.
  always_comb begin
    stage_en   = 3'b001;
    total_time = SPIN_STAGE_T;
    case (mode)
      MODE_STANDARD: begin
        stage_en   = 3'b111;
        total_time = WASH_STAGE_T + RINSE_STAGE_T + SPIN_STAGE_T;
      end
      MODE_QUICK: begin
        stage_en   = 3'b101;
        total_time = WASH_STAGE_T + SPIN_STAGE_T;
      end
      MODE_RINSE_SPIN: begin
        stage_en   = 3'b011;
        total_time = RINSE_STAGE_T + SPIN_STAGE_T;
      end
      default: begin
        stage_en   = 3'b001;
        total_time = SPIN_STAGE_T;
      end
    endcase
  end

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: runs wash/rinse/spin stages on the
// 1 Hz tick, handles start/pause and clothes-add, drives lights and timer.
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int unsigned FILL_T  = DEF_FILL_T,
  parameter int unsigned WASH_T  = DEF_WASH_T,
  parameter int unsigned RINSE_T = DEF_RINSE_T,
  parameter int unsigned DRAIN_T = DEF_DRAIN_T,
  parameter int unsigned SPIN_T  = DEF_SPIN_T,
  parameter int unsigned BUZZ_T  = DEF_BUZZ_T
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       start_pulse,
  input  logic       mode_pulse,
  input  logic       add_pulse,
  output logic [1:0] mode,
  output logic       start_light,
  output logic       wash_light,
  output logic       dwash_light,
  output logic       dry_light,
  output logic       inwater_light,
  output logic       outwater_light,
  output logic       buzzer_light,
  output logic [6:0] remain_time,
  output logic       done
);

  // Total of the standard program, shown on the display straight out of reset.
  localparam logic [6:0] RESET_TOTAL =
    7'(2 * FILL_T + WASH_T + RINSE_T + 2 * DRAIN_T + SPIN_T);

  top_state_e state_q, state_d;
  phase_e     phase_q, phase_d;
  stage_e     stage_q, stage_d;
  logic [1:0] mode_q, mode_d;
  logic [6:0] phase_cnt_q, phase_cnt_d;
  logic [6:0] buzz_cnt_q, buzz_cnt_d;
  logic [6:0] remain_q, remain_d;
  logic       done_q, done_d;
  logic       start_light_q, start_light_d;
  logic       wash_light_q, wash_light_d;
  logic       dwash_light_q, dwash_light_d;
  logic       dry_light_q, dry_light_d;
  logic       inwater_q, inwater_d;
  logic       outwater_q, outwater_d;
  logic       buzzer_q, buzzer_d;

  logic [2:0] plan_en;
  logic [6:0] plan_total;
  logic       add_ok;
  logic       active_d;

  // The plan is looked up for the next mode so the IDLE display tracks a
  // mode change on the same edge that registers it.
  wash_plan #(
    .FILL_T (FILL_T),
    .WASH_T (WASH_T),
    .RINSE_T(RINSE_T),
    .DRAIN_T(DRAIN_T),
    .SPIN_T (SPIN_T)
  ) u_plan (
    .mode      (mode_d),
    .stage_en  (plan_en),
    .total_time(plan_total)
  );

  function automatic logic [6:0] phase_len(input phase_e ph, input stage_e st);
    case (ph)
      PH_FILL:    return 7'(FILL_T);
      PH_AGITATE: return (st == STG_WASH) ? 7'(WASH_T) : 7'(RINSE_T);
      PH_DRAIN:   return 7'(DRAIN_T);
      default:    return 7'(SPIN_T);
    endcase
  endfunction

  function automatic stage_e first_stage(input logic [2:0] en);
    if (en[EN_WASH])       return STG_WASH;
    else if (en[EN_RINSE]) return STG_RINSE;
    else                   return STG_SPIN;
  endfunction

  function automatic phase_e entry_phase(input stage_e st);
    return (st == STG_SPIN) ? PH_SPIN : PH_FILL;
  endfunction

  // Program select only moves in IDLE, and a simultaneous start wins.
  always_comb begin
    mode_d = mode_q;
    if (state_q == ST_IDLE && !start_pulse && mode_pulse) begin
      mode_d = next_mode(mode_q);
    end
  end

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    stage_d     = stage_q;
    phase_cnt_d = phase_cnt_q;
    buzz_cnt_d  = buzz_cnt_q;
    remain_d    = remain_q;
    done_d      = 1'b0;
    // Clothes may only be added while the wash tub is filling or agitating.
    add_ok = (stage_q == STG_WASH) &&
             (phase_q == PH_FILL || phase_q == PH_AGITATE);

    case (state_q)
      ST_IDLE: begin
        remain_d = plan_total;
        if (start_pulse) begin
          state_d     = ST_RUN;
          stage_d     = first_stage(plan_en);
          phase_d     = entry_phase(stage_d);
          phase_cnt_d = phase_len(phase_d, stage_d);
        end
      end

      ST_RUN: begin
        if (tick_1hz) begin
          if (remain_q == 7'd1) begin
            state_d    = ST_DONE;
            remain_d   = 7'd0;
            buzz_cnt_d = 7'(BUZZ_T);
          end else begin
            remain_d = remain_q - 7'd1;
            if (phase_cnt_q == 7'd1) begin
              case (phase_q)
                PH_FILL:    phase_d = PH_AGITATE;
                PH_AGITATE: phase_d = PH_DRAIN;
                PH_DRAIN: begin
                  if (stage_q == STG_WASH && plan_en[EN_RINSE]) begin
                    stage_d = STG_RINSE;
                    phase_d = PH_FILL;
                  end else begin
                    stage_d = STG_SPIN;
                    phase_d = PH_SPIN;
                  end
                end
                default:    phase_d = PH_SPIN;
              endcase
              phase_cnt_d = phase_len(phase_d, stage_d);
            end else begin
              phase_cnt_d = phase_cnt_q - 7'd1;
            end
          end
        end
        // Pause requests act after any same-cycle tick has been applied.
        if (state_d == ST_RUN && (start_pulse || (add_pulse && add_ok))) begin
          state_d = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        if (start_pulse) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        if (tick_1hz) begin
          if (buzz_cnt_q == 7'd1) begin
            state_d  = ST_IDLE;
            done_d   = 1'b1;
            remain_d = plan_total;
          end else begin
            buzz_cnt_d = buzz_cnt_q - 7'd1;
          end
        end
      end
    endcase

    // Lights follow the next state so they land one clock after the event.
    active_d      = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    start_light_d = (state_d == ST_RUN);
    wash_light_d  = active_d && (stage_d == STG_WASH);
    dwash_light_d = active_d && (stage_d == STG_RINSE);
    dry_light_d   = active_d && (stage_d == STG_SPIN);
    inwater_d     = (state_d == ST_RUN) && (phase_d == PH_FILL);
    outwater_d    = (state_d == ST_RUN) &&
                    (phase_d == PH_DRAIN || phase_d == PH_SPIN);
    buzzer_d      = (state_d == ST_DONE);
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      phase_q       <= PH_FILL;
      stage_q       <= STG_WASH;
      mode_q        <= MODE_STANDARD;
      phase_cnt_q   <= 7'd0;
      buzz_cnt_q    <= 7'd0;
      remain_q      <= RESET_TOTAL;
      done_q        <= 1'b0;
      start_light_q <= 1'b0;
      wash_light_q  <= 1'b0;
      dwash_light_q <= 1'b0;
      dry_light_q   <= 1'b0;
      inwater_q     <= 1'b0;
      outwater_q    <= 1'b0;
      buzzer_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      stage_q       <= stage_d;
      mode_q        <= mode_d;
      phase_cnt_q   <= phase_cnt_d;
      buzz_cnt_q    <= buzz_cnt_d;
      remain_q      <= remain_d;
      done_q        <= done_d;
      start_light_q <= start_light_d;
      wash_light_q  <= wash_light_d;
      dwash_light_q <= dwash_light_d;
      dry_light_q   <= dry_light_d;
      inwater_q     <= inwater_d;
      outwater_q    <= outwater_d;
      buzzer_q      <= buzzer_d;
    end
  end

  assign mode           = mode_q;
  assign start_light    = start_light_q;
  assign wash_light     = wash_light_q;
  assign dwash_light    = dwash_light_q;
  assign dry_light      = dry_light_q;
  assign inwater_light  = inwater_q;
  assign outwater_light = outwater_q;
  assign buzzer_light   = buzzer_q;
  assign remain_time    = remain_q;
  assign done           = done_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: directed scenarios plus random pulses, every
// cycle compared against a timeline-based reference model.
module tb_wash_sequencer;

  localparam int FILL  = 3;
  localparam int WASH  = 9;
  localparam int RINSE = 6;
  localparam int DRAIN = 3;
  localparam int SPIN  = 6;
  localparam int BUZZ  = 10;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic       start_pulse;
  logic       mode_pulse;
  logic       add_pulse;
  logic [1:0] mode;
  logic       start_light;
  logic       wash_light;
  logic       dwash_light;
  logic       dry_light;
  logic       inwater_light;
  logic       outwater_light;
  logic       buzzer_light;
  logic [6:0] remain_time;
  logic       done;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: program position is just "seconds elapsed".
  int m_mode;
  int m_state;
  int m_elapsed;
  int m_buzz;
  bit m_done;

  wash_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .tick_1hz      (tick_1hz),
    .start_pulse   (start_pulse),
    .mode_pulse    (mode_pulse),
    .add_pulse     (add_pulse),
    .mode          (mode),
    .start_light   (start_light),
    .wash_light    (wash_light),
    .dwash_light   (dwash_light),
    .dry_light     (dry_light),
    .inwater_light (inwater_light),
    .outwater_light(outwater_light),
    .buzzer_light  (buzzer_light),
    .remain_time   (remain_time),
    .done          (done)
  );

  always #5 clk = ~clk;

  function automatic bit has_wash(input int md);
    return (md == 0) || (md == 1);
  endfunction

  function automatic bit has_rinse(input int md);
    return (md == 0) || (md == 2);
  endfunction

  function automatic int prog_total(input int md);
    int t;
    t = SPIN;
    if (has_wash(md))  t += FILL + WASH + DRAIN;
    if (has_rinse(md)) t += FILL + RINSE + DRAIN;
    return t;
  endfunction

  // Which lights belong to second e of program md (walks the stage list).
  function automatic void lights_at(input int md, input int e,
                                    output bit w, output bit r, output bit s,
                                    output bit fin, output bit fout);
    int t;
    t = e; w = 0; r = 0; s = 0; fin = 0; fout = 0;
    if (has_wash(md)) begin
      if (t < FILL + WASH + DRAIN) begin
        w = 1; fin = (t < FILL); fout = (t >= FILL + WASH);
        return;
      end
      t -= FILL + WASH + DRAIN;
    end
    if (has_rinse(md)) begin
      if (t < FILL + RINSE + DRAIN) begin
        r = 1; fin = (t < FILL); fout = (t >= FILL + RINSE);
        return;
      end
    end
    s = 1; fout = 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_state = S_IDLE; m_elapsed = 0; m_buzz = 0; m_done = 0;
  endtask

  task automatic model_step(input bit t, input bit s, input bit m, input bit a);
    bit w, r, sp, fi, fo, add_ok;
    m_done = 0;
    case (m_state)
      S_IDLE: begin
        if (s) begin
          m_state = S_RUN; m_elapsed = 0;
        end else if (m) begin
          m_mode = (m_mode + 1) % 4;
        end
      end
      S_RUN: begin
        lights_at(m_mode, m_elapsed, w, r, sp, fi, fo);
        add_ok = w && !fo;
        if (t) begin
          m_elapsed++;
          if (m_elapsed == prog_total(m_mode)) begin
            m_state = S_DONE; m_buzz = BUZZ;
          end
        end
        if (m_state == S_RUN && (s || (a && add_ok))) m_state = S_PAUSE;
      end
      S_PAUSE: if (s) m_state = S_RUN;
      default: begin
        if (t) begin
          m_buzz--;
          if (m_buzz == 0) begin
            m_state = S_IDLE; m_done = 1;
          end
        end
      end
    endcase
  endtask

  task automatic compare_all();
    bit w, r, s, fi, fo;
    int exp_remain;
    w = 0; r = 0; s = 0; fi = 0; fo = 0;
    if (m_state == S_RUN || m_state == S_PAUSE)
      lights_at(m_mode, m_elapsed, w, r, s, fi, fo);
    case (m_state)
      S_IDLE:  exp_remain = prog_total(m_mode);
      S_DONE:  exp_remain = 0;
      default: exp_remain = prog_total(m_mode) - m_elapsed;
    endcase
    check("mode", mode, m_mode);
    check("start_light", start_light, m_state == S_RUN);
    check("wash_light", wash_light, w);
    check("dwash_light", dwash_light, r);
    check("dry_light", dry_light, s);
    check("inwater_light", inwater_light, (m_state == S_RUN) && fi);
    check("outwater_light", outwater_light, (m_state == S_RUN) && fo);
    check("buzzer_light", buzzer_light, m_state == S_DONE);
    check("remain_time", remain_time, exp_remain);
    check("done", done, m_done);
  endtask

  // One clock with the given pulses, then model update and full compare.
  task automatic cycle(input bit t, input bit s, input bit m, input bit a);
    tick_1hz = t; start_pulse = s; mode_pulse = m; add_pulse = a;
    @(posedge clk);
    #1;
    tick_1hz = 0; start_pulse = 0; mode_pulse = 0; add_pulse = 0;
    model_step(t, s, m, a);
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0);
    end
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    compare_all();
  endtask

  initial begin
    bit t, s, m, a;
    reset = 1; tick_1hz = 0; start_pulse = 0; mode_pulse = 0; add_pulse = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset state and program totals.
    do_reset();
    check("reset_remain", remain_time, 33);
    check("reset_mode", mode, 0);
    check("reset_start_light", start_light, 0);

    // Mode 2 full program.
    cycle(0, 0, 1, 0);
    check("mode1_total", remain_time, 21);
    cycle(0, 0, 1, 0);
    check("mode2_total", remain_time, 18);
    cycle(0, 1, 0, 0);
    check("m2_first_fill", inwater_light, 1);
    check("m2_rinse_light", dwash_light, 1);
    ticks(3);
    check("m2_fill_over", inwater_light, 0);
    ticks(15);
    check("m2_buzzer_on", buzzer_light, 1);
    check("m2_remain_zero", remain_time, 0);
    ticks(9);
    cycle(1, 0, 0, 0);
    check("m2_done_pulse", done, 1);
    cycle(0, 0, 0, 0);
    check("m2_done_low", done, 0);
    check("m2_idle_remain", remain_time, 18);

    // Mode 0 with a pause in the middle.
    do_reset();
    cycle(0, 1, 0, 0);
    ticks(5);
    check("m0_remain_before_pause", remain_time, 28);
    cycle(0, 1, 0, 0);
    ticks(4);
    check("m0_pause_hold", remain_time, 28);
    check("m0_pause_inwater", inwater_light, 0);
    check("m0_pause_outwater", outwater_light, 0);
    check("m0_pause_wash_held", wash_light, 1);
    cycle(0, 1, 0, 0);
    ticks(28);
    check("m0_complete_remain", remain_time, 0);
    check("m0_complete_buzzer", buzzer_light, 1);
    ticks(BUZZ);

    // Clothes-add during wash agitate pauses; during rinse it is ignored.
    cycle(0, 1, 0, 0);
    ticks(4);
    cycle(0, 0, 0, 1);
    check("add_agitate_pauses", start_light, 0);
    cycle(0, 1, 0, 0);
    ticks(9);
    check("remain_20", remain_time, 20);
    cycle(1, 1, 0, 0);
    check("tick_start_remain", remain_time, 19);
    check("tick_start_paused", start_light, 0);
    cycle(0, 1, 0, 0);
    ticks(3);
    cycle(0, 0, 0, 1);
    check("add_rinse_ignored", start_light, 1);
    check("add_rinse_dwash", dwash_light, 1);
    ticks(11);
    check("in_spin", dry_light, 1);

    // Reset during spin, then mode select still works.
    do_reset();
    check("rst_spin_dry", dry_light, 0);
    check("rst_spin_remain", remain_time, 33);
    cycle(0, 0, 1, 0);
    check("post_reset_mode", mode, 1);
    check("post_reset_remain", remain_time, 21);

    // Start and mode pulse together in IDLE: start wins.
    cycle(0, 1, 1, 0);
    check("start_beats_mode", mode, 1);
    do_reset();

    // Random pulse traffic against the model.
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 400; k++) begin
        if ($urandom_range(0, 499) == 0) begin
          do_reset();
        end else begin
          t = ($urandom_range(0, 1) == 0);
          s = ($urandom_range(0, 24) == 0);
          m = ($urandom_range(0, 7) == 0);
          a = ($urandom_range(0, 11) == 0);
          cycle(t, s, m, a);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wash_sequencer.md
# wash_sequencer

Program sequencer for the washing-machine controller. Runs the selected wash program stage by stage (wash, rinse, spin). Each stage is split into fill, agitate, drain and spin phases, driven by the 1 Hz tick from the clock divider. Drives the stage/valve/buzzer lights and the remaining-time value for the seven-segment display, and handles start/pause and clothes-add requests. It sits below the power-switch logic, which holds it in reset while power is off and consumes `done` for auto power-off.

## Interface
- `FILL_T`, 3: fill duration per wash/rinse stage, in ticks (≥1).
- `WASH_T`, 9: wash agitate ticks (≥1).
- `RINSE_T`, 6: rinse agitate ticks (≥1).
- `DRAIN_T`, 3: drain ticks per wash/rinse stage (≥1).
- `SPIN_T`, 6: spin ticks (≥1).
- `BUZZ_T`, 10: buzzer-on ticks after completion (≥1).
- `clk` in 1: 100 MHz system clock.
- `reset` in 1: synchronous, active-high.
- `tick_1hz` in 1: one-`clk` pulse per second.
- `start_pulse` in 1: debounced one-cycle start/pause request.
- `mode_pulse` in 1: one-cycle program-select request.
- `add_pulse` in 1: one-cycle clothes-add request.
- `mode` out 2: selected program.
- `start_light` out 1: program running (not paused, not idle).
- `wash_light`, `dwash_light`, `dry_light` out 1 each: wash / rinse / spin stage active.
- `inwater_light` out 1: fill phase active and running.
- `outwater_light` out 1: drain or spin phase active and running.
- `buzzer_light` out 1: completion buzzer.
- `remain_time` out 7: seconds remaining in the program.
- `done` out 1: single-cycle pulse when the buzzer period ends.

## Operation
- Programs and their totals with default parameters:
  - mode 0, standard: wash + rinse + spin, 33 s.
  - mode 1, quick: wash + spin, 21 s.
  - mode 2: rinse + spin, 18 s.
  - mode 3: spin only, 6 s.
- Stage durations:
  - Wash stage = FILL, AGITATE(`WASH_T`), DRAIN.
  - Rinse stage = FILL, AGITATE(`RINSE_T`), DRAIN.
  - Spin stage = SPIN.
- Parameter sums must be ≤127. All arithmetic is unsigned 7-bit.
- Top-level states: IDLE, RUN, PAUSE, DONE.
- Phase state: FILL, AGITATE, DRAIN, SPIN.
- Stage register: WASH, RINSE, SPIN.
- IDLE:
  - `mode_pulse` advances `mode` 0→1→2→3→0.
  - `remain_time` shows the total for the current mode.
  - `start_pulse` → RUN, entering the first enabled stage at its first phase, with the phase counter loaded.
- RUN: on each `tick_1hz`:
  - the phase counter decrements and `remain_time` decrements;
  - when the phase counter was 1, advance to the next phase or stage and load its duration;
  - when `remain_time` was 1, go to DONE and load the buzzer counter with `BUZZ_T`.
- RUN + `start_pulse` → PAUSE. PAUSE + `start_pulse` → RUN.
- PAUSE:
  - ticks are ignored;
  - `inwater_light` and `outwater_light` are 0;
  - stage lights hold their values.
- `add_pulse` in RUN, stage WASH, phase FILL or AGITATE → PAUSE. Ignored in all other cases.
- DONE:
  - `buzzer_light`=1; all stage and valve lights are 0;
  - `remain_time`=0;
  - the buzzer counter decrements per tick;
  - on the tick where it was 1: `done`=1 for one cycle, `buzzer_light`=0, state → IDLE.
- Pulses in DONE are ignored.
- Reset values:
  - state IDLE, `mode`=0, `remain_time`=33 (total for mode 0);
  - all lights 0, `done`=0.

## Timing
- All outputs are registered. Lights and `remain_time` update one `clk` after the triggering pulse or tick.
- Events are evaluated against the state at the start of the cycle:
  - tick + `start_pulse` in RUN: the tick is applied, then PAUSE;
  - tick + `start_pulse` in PAUSE: the tick is ignored, then RUN;
  - tick + `start_pulse` in IDLE: the tick is ignored.
- In IDLE, `start_pulse` + `mode_pulse` in the same cycle: start wins; `mode` is unchanged.
- In RUN, `add_pulse` + `start_pulse` in the same cycle (eligible phase): PAUSE.
- `reset` mid-program: return to IDLE next cycle. `mode` also resets to 0.
- First `remain_time` decrement happens on the first tick after entering RUN.

## Structure
- Package `wash_pkg` holds:
  - top-state, phase and stage enums;
  - mode codes;
  - default duration constants.
- Sub-module `wash_plan` (combinational) maps `mode` → stage-enable mask {wash, rinse, spin} and the 7-bit total time.
- `wash_sequencer` instantiates `wash_plan` and holds the FSM plus the phase and buzzer counters.

## Test plan
- Reset; mode_pulse ×2; start; 18 ticks. Required sequence:
  - `remain_time` 18→0;
  - `dwash_light` 12 ticks;
  - `inwater_light` for ticks 1–3, `outwater_light` for ticks 10–18;
  - `dry_light` for the last 6 ticks;
  - `buzzer_light` for 10 ticks;
  - `done` pulse, then IDLE with `remain_time`=18.
- Mode 0: start, 5 ticks, start, 4 ticks, start, 28 ticks.
  - `remain_time` is held at 28 during the pause; valves are 0 during the pause.
  - Completes with `remain_time`=0.
- Mode 0: `add_pulse` at AGITATE → PAUSE.
- Mode 0: `add_pulse` during rinse → ignored; `start_light` stays 1.
- `start_pulse` and `tick_1hz` in the same cycle while in RUN with `remain_time`=20 → `remain_time`=19, state PAUSE.
- `reset` during spin → next cycle: all lights 0, `mode`=0, `remain_time`=33; a subsequent `mode_pulse` still works.
